// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI master, SCLK idle low, data sampled on the SCLK rising
//               edge and changed on the falling edge, MSB first. Optional
//               burst mode (keep SSEL low across packets) is enabled by
//               defining SPI_MASTER_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int PACKET_WIDTH = 8,
    parameter int CLK_DIV      = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    keepSelect,
    input  logic [PACKET_WIDTH-1:0] txPacket,
    output logic                    busy,
    output logic                    done,
    output logic [PACKET_WIDTH-1:0] rxPacket,
    output logic                    spi_SCLK,
    output logic                    spi_SSEL,
    output logic                    spi_MOSI,
    input  logic                    spi_MISO
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(PACKET_WIDTH + 1);

    localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_BITS_LAST = CNT_W'(PACKET_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_BITS_ALL  = CNT_W'(PACKET_WIDTH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LEAD  = 3'd1;
    localparam logic [2:0] c_ST_HIGH  = 3'd2;
    localparam logic [2:0] c_ST_LOW   = 3'd3;
    localparam logic [2:0] c_ST_GUARD = 3'd4;
    localparam logic [2:0] c_ST_HOLD  = 3'd5;

    logic [2:0]              r_state;
    logic [DIV_W-1:0]        r_div;
    logic [CNT_W-1:0]        r_bits;
    logic [PACKET_WIDTH-1:0] r_tx;
    logic [PACKET_WIDTH-1:0] r_rx;
    logic [PACKET_WIDTH-1:0] r_rx_out;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_sclk;
    logic                    r_ssel;

    logic                    w_div_last;
    logic                    w_accept;
    logic                    w_hold;
    logic [PACKET_WIDTH-1:0] w_rx_shift;

    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_accept   = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_HOLD));
    assign w_rx_shift = {r_rx[PACKET_WIDTH-2:0], spi_MISO};

`ifdef SPI_MASTER_BURST_EN
    logic r_keep;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_keep <= 1'b0;
        end else if (w_accept) begin
            r_keep <= keepSelect;
        end
    end

    assign w_hold = r_keep;
`else
    logic w_unused_keep;

    assign w_unused_keep = keepSelect;
    assign w_hold        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_div    <= '0;
            r_bits   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_rx_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sclk   <= 1'b0;
            r_ssel   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_HOLD: begin
                    if (w_accept) begin
                        r_tx    <= txPacket;
                        r_div   <= '0;
                        r_bits  <= '0;
                        r_busy  <= 1'b1;
                        r_ssel  <= 1'b0;
                        r_state <= c_ST_LEAD;
                    end
                end
                c_ST_LEAD: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= w_rx_shift;
                        r_state <= c_ST_HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_HIGH: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_bits  <= r_bits + 1'b1;
                        // MOSI keeps the LSB once the last bit has been sent
                        if (r_bits != c_BITS_LAST) begin
                            r_tx <= r_tx << 1;
                        end
                        r_state <= c_ST_LOW;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_LOW: begin
                    if (w_div_last) begin
                        r_div <= '0;
                        if (r_bits == c_BITS_ALL) begin
                            r_done   <= 1'b1;
                            r_rx_out <= r_rx;
                            if (w_hold) begin
                                r_busy  <= 1'b0;
                                r_state <= c_ST_HOLD;
                            end else begin
                                r_ssel  <= 1'b1;
                                r_state <= c_ST_GUARD;
                            end
                        end else begin
                            r_sclk  <= 1'b1;
                            r_rx    <= w_rx_shift;
                            r_state <= c_ST_HIGH;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_GUARD: begin
                    if (w_div_last) begin
                        r_div   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rxPacket = r_rx_out;
    assign spi_SCLK = r_sclk;
    assign spi_SSEL = r_ssel;
    assign spi_MOSI = r_tx[PACKET_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master with a bit-stream slave
//               and a phase/latency monitor. Burst scenario needs
//               SPI_MASTER_BURST_EN defined for both bench and design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int W   = 8;
    localparam int DIV = 5;
    localparam int LAT = DIV * (2 * W + 1) + 1;
    localparam int LIM = 3 * LAT;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         keepSelect;
    logic [W-1:0] txPacket;
    logic         busy;
    logic         done;
    logic [W-1:0] rxPacket;
    logic         spi_SCLK;
    logic         spi_SSEL;
    logic         spi_MOSI;
    logic         spi_MISO;

    int n_chk  = 0;
    int n_pass = 0;

    int   cyc    = 0;
    int   done_n = 0;
    int   rise_q[$];
    int   fall_q[$];
    int   sfall_q[$];
    int   srise_q[$];
    logic mosi_q[$];

    logic sl_bits[$];
    int   sl_epoch = 0;

    always #5 clk = ~clk;

    spi_master #(.PACKET_WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .keepSelect (keepSelect),
        .txPacket   (txPacket),
        .busy       (busy),
        .done       (done),
        .rxPacket   (rxPacket),
        .spi_SCLK   (spi_SCLK),
        .spi_SSEL   (spi_SSEL),
        .spi_MOSI   (spi_MOSI),
        .spi_MISO   (spi_MISO)
    );

    // Bus monitor: records the cycle of every SCLK/SSEL edge and MOSI at each rise
    initial begin
        logic p_sclk;
        logic p_ssel;
        p_sclk = 1'b0;
        p_ssel = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (spi_SCLK === 1'b1 && p_sclk === 1'b0) begin
                rise_q.push_back(cyc);
                mosi_q.push_back(spi_MOSI);
            end
            if (spi_SCLK === 1'b0 && p_sclk === 1'b1) fall_q.push_back(cyc);
            if (spi_SSEL === 1'b0 && p_ssel === 1'b1) sfall_q.push_back(cyc);
            if (spi_SSEL === 1'b1 && p_ssel === 1'b0) srise_q.push_back(cyc);
            if (done === 1'b1) done_n++;
            p_sclk = spi_SCLK;
            p_ssel = spi_SSEL;
        end
    end

    // Slave: presents a continuous MSB-first bit stream, advancing on SCLK fall
    initial begin
        int my_epoch;
        int ptr;
        my_epoch = 0;
        ptr      = 0;
        spi_MISO = 1'b0;
        forever begin
            @(negedge spi_SCLK or sl_epoch);
            if (sl_epoch != my_epoch) begin
                my_epoch = sl_epoch;
                ptr      = 0;
            end else begin
                ptr++;
            end
            spi_MISO = (ptr < sl_bits.size()) ? sl_bits[ptr] : 1'b0;
        end
    end

    task automatic slave_load(input logic [W-1:0] w0, input logic [W-1:0] w1);
        sl_bits.delete();
        for (int i = W - 1; i >= 0; i--) sl_bits.push_back(w0[i]);
        for (int i = W - 1; i >= 0; i--) sl_bits.push_back(w1[i]);
        sl_epoch++;
    endtask

    function automatic logic [W-1:0] mosi_word(input int base);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (base + i < mosi_q.size()) w[W-1-i] = mosi_q[base+i];
        end
        return w;
    endfunction

    // Issues one start from idle and waits (bounded) for done; lat counts cycles from the start cycle
    task automatic xfer(input logic [W-1:0] tx, input logic keep, output int lat);
        @(negedge clk);
        start      = 1'b1;
        txPacket   = tx;
        keepSelect = keep;
        @(negedge clk);
        start      = 1'b0;
        txPacket   = W'($urandom);
        keepSelect = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < LIM) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        start      = 1'b1;
        keepSelect = 1'b0;
        txPacket   = 8'hff;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_chk++; if (rxPacket !== '0) $display("FAIL reset_rx got=%h exp=00", rxPacket); else n_pass++;
        n_chk++; if (spi_SSEL !== 1'b1) $display("FAIL reset_ssel got=%b exp=1", spi_SSEL); else n_pass++;
        n_chk++; if (spi_SCLK !== 1'b0) $display("FAIL reset_sclk got=%b exp=0", spi_SCLK); else n_pass++;
        n_chk++; if (spi_MOSI !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", spi_MOSI); else n_pass++;
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        int rb;
        int db;
        rb = rise_q.size();
        db = done_n;
        slave_load(8'hff, 8'h00);
        xfer(8'hab, 1'b0, lat);
        n_chk++; if (lat !== LAT) $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_chk++; if (rxPacket !== 8'hff) $display("FAIL single_rx got=%h exp=ff", rxPacket); else n_pass++;
        n_chk++; if (mosi_word(rb) !== 8'hab) $display("FAIL single_mosi got=%h exp=ab", mosi_word(rb)); else n_pass++;
        wait_idle();
        n_chk++; if (rise_q.size() - rb !== W) $display("FAIL single_rises got=%0d exp=%0d", rise_q.size() - rb, W); else n_pass++;
        n_chk++; if (done_n - db !== 1) $display("FAIL single_done_count got=%0d exp=1", done_n - db); else n_pass++;
        n_chk++; if (spi_MOSI !== 1'b1) $display("FAIL idle_mosi_hold got=%b exp=1", spi_MOSI); else n_pass++;
    endtask

    task automatic test_timing();
        int lat;
        int rb;
        int fb;
        int sb;
        int rsb;
        int bad_hi;
        int bad_lo;
        logic [W-1:0] tx;
        rb  = rise_q.size();
        fb  = fall_q.size();
        sb  = sfall_q.size();
        rsb = srise_q.size();
        tx  = W'($urandom);
        slave_load(W'($urandom), 8'h00);
        xfer(tx, 1'b0, lat);
        wait_idle();
        n_chk++;
        if (rise_q.size() - rb < W || fall_q.size() - fb < W || sfall_q.size() - sb < 1 || srise_q.size() - rsb < 1) begin
            $display("FAIL timing_edges rises=%0d falls=%0d exp=%0d", rise_q.size() - rb, fall_q.size() - fb, W);
        end else begin
            n_pass++;
            bad_hi = 0;
            bad_lo = 0;
            for (int i = 0; i < W; i++) begin
                if (fall_q[fb+i] - rise_q[rb+i] != DIV) bad_hi = fall_q[fb+i] - rise_q[rb+i];
                if (i < W - 1 && rise_q[rb+i+1] - fall_q[fb+i] != DIV) bad_lo = rise_q[rb+i+1] - fall_q[fb+i];
            end
            n_chk++; if (rise_q[rb] - sfall_q[sb] !== DIV) $display("FAIL timing_lead got=%0d exp=%0d", rise_q[rb] - sfall_q[sb], DIV); else n_pass++;
            n_chk++; if (bad_hi !== 0) $display("FAIL timing_high got=%0d exp=%0d", bad_hi, DIV); else n_pass++;
            n_chk++; if (bad_lo !== 0) $display("FAIL timing_low got=%0d exp=%0d", bad_lo, DIV); else n_pass++;
            n_chk++; if (srise_q[rsb] - fall_q[fb+W-1] !== DIV) $display("FAIL timing_last_low got=%0d exp=%0d", srise_q[rsb] - fall_q[fb+W-1], DIV); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] txs[4];
        logic [W-1:0] sls[4];
        int lat;
        int rb;
        int rsb;
        int sb;
        txs = '{8'h15, 8'hab, W'($urandom), W'($urandom)};
        sls = '{8'ha5, 8'h3c, W'($urandom), W'($urandom)};
        for (int k = 0; k < 4; k++) begin
            rb  = rise_q.size();
            rsb = srise_q.size();
            sb  = sfall_q.size();
            slave_load(sls[k], 8'h00);
            xfer(txs[k], 1'b0, lat);
            n_chk++; if (rxPacket !== sls[k]) $display("FAIL b2b_rx[%0d] got=%h exp=%h", k, rxPacket, sls[k]); else n_pass++;
            n_chk++; if (mosi_word(rb) !== txs[k]) $display("FAIL b2b_mosi[%0d] got=%h exp=%h", k, mosi_word(rb), txs[k]); else n_pass++;
            if (k > 0) begin
                n_chk++;
                if (rsb < 1 || sb >= sfall_q.size() || sfall_q[sb] - srise_q[rsb-1] < DIV)
                    $display("FAIL b2b_ssel_gap[%0d] got=%0d exp>=%0d", k, (rsb < 1 || sb >= sfall_q.size()) ? -1 : sfall_q[sb] - srise_q[rsb-1], DIV);
                else n_pass++;
            end
            wait_idle();
        end
    endtask

    task automatic test_busy_drop();
        logic [W-1:0] a;
        logic [W-1:0] slv;
        int rb;
        int db;
        int sb;
        int n;
        a   = W'($urandom);
        slv = W'($urandom);
        rb  = rise_q.size();
        db  = done_n;
        sb  = sfall_q.size();
        slave_load(slv, 8'h00);
        @(negedge clk);
        start    = 1'b1;
        txPacket = a;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        start    = 1'b1;
        txPacket = ~a;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * LAT) @(negedge clk);
        n_chk++; if (done_n - db !== 1) $display("FAIL drop_done_count got=%0d exp=1", done_n - db); else n_pass++;
        n_chk++; if (rise_q.size() - rb !== W) $display("FAIL drop_rises got=%0d exp=%0d", rise_q.size() - rb, W); else n_pass++;
        n_chk++; if (sfall_q.size() - sb !== 1) $display("FAIL drop_selects got=%0d exp=1", sfall_q.size() - sb); else n_pass++;
        n_chk++; if (mosi_word(rb) !== a) $display("FAIL drop_mosi got=%h exp=%h", mosi_word(rb), a); else n_pass++;
        n_chk++; if (rxPacket !== slv) $display("FAIL drop_rx got=%h exp=%h", rxPacket, slv); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int rb;
        int db;
        int n;
        rb = rise_q.size();
        db = done_n;
        slave_load(8'h5a, 8'h00);
        @(negedge clk);
        start    = 1'b1;
        txPacket = W'($urandom);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rise_q.size() - rb < 4 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_chk++; if (spi_SSEL !== 1'b1) $display("FAIL abort_ssel got=%b exp=1", spi_SSEL); else n_pass++;
        n_chk++; if (spi_SCLK !== 1'b0) $display("FAIL abort_sclk got=%b exp=0", spi_SCLK); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (rxPacket !== '0) $display("FAIL abort_rx got=%h exp=00", rxPacket); else n_pass++;
        reset_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        n_chk++; if (done_n - db !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_n - db); else n_pass++;
        n_chk++; if (rxPacket !== '0) $display("FAIL abort_rx_after got=%h exp=00", rxPacket); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] tx;
        logic [W-1:0] slv;
        int lat;
        int rb;
        for (int k = 0; k < 6; k++) begin
            tx  = W'($urandom);
            slv = W'($urandom);
            rb  = rise_q.size();
            slave_load(slv, 8'h00);
            xfer(tx, 1'b0, lat);
            n_chk++; if (lat !== LAT) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", k, lat, LAT); else n_pass++;
            n_chk++; if (rxPacket !== slv) $display("FAIL rand_rx[%0d] got=%h exp=%h", k, rxPacket, slv); else n_pass++;
            n_chk++; if (mosi_word(rb) !== tx) $display("FAIL rand_mosi[%0d] got=%h exp=%h", k, mosi_word(rb), tx); else n_pass++;
            wait_idle();
        end
    endtask

`ifdef SPI_MASTER_BURST_EN
    task automatic test_burst();
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        int lat;
        int rb;
        int sb;
        int rsb;
        w0  = W'($urandom);
        w1  = W'($urandom);
        rb  = rise_q.size();
        sb  = sfall_q.size();
        rsb = srise_q.size();
        slave_load(w0, w1);
        xfer(8'hab, 1'b1, lat);
        n_chk++; if (rxPacket !== w0) $display("FAIL burst_rx0 got=%h exp=%h", rxPacket, w0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL burst_hold_busy got=%b exp=0", busy); else n_pass++;
        keepSelect = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (spi_SSEL !== 1'b0) $display("FAIL burst_hold_ssel got=%b exp=0", spi_SSEL); else n_pass++;
        xfer(8'h15, 1'b0, lat);
        n_chk++; if (lat !== LAT) $display("FAIL burst_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        n_chk++; if (rxPacket !== w1) $display("FAIL burst_rx1 got=%h exp=%h", rxPacket, w1); else n_pass++;
        n_chk++; if (mosi_word(rb + W) !== 8'h15) $display("FAIL burst_mosi1 got=%h exp=15", mosi_word(rb + W)); else n_pass++;
        wait_idle();
        n_chk++; if (rise_q.size() - rb !== 2 * W) $display("FAIL burst_rises got=%0d exp=%0d", rise_q.size() - rb, 2 * W); else n_pass++;
        n_chk++; if (srise_q.size() - rsb !== 1) $display("FAIL burst_ssel_rises got=%0d exp=1", srise_q.size() - rsb); else n_pass++;
        n_chk++; if (sfall_q.size() - sb !== 1) $display("FAIL burst_ssel_falls got=%0d exp=1", sfall_q.size() - sb); else n_pass++;
    endtask
`else
    task automatic test_keep_ignored();
        int lat;
        int rsb;
        rsb = srise_q.size();
        slave_load(8'hc3, 8'h00);
        xfer(8'h81, 1'b1, lat);
        wait_idle();
        n_chk++; if (srise_q.size() - rsb !== 1) $display("FAIL keep_ignored_ssel got=%0d exp=1", srise_q.size() - rsb); else n_pass++;
        n_chk++; if (rxPacket !== 8'hc3) $display("FAIL keep_ignored_rx got=%h exp=c3", rxPacket); else n_pass++;
    endtask
`endif

    initial begin
        start      = 1'b0;
        keepSelect = 1'b0;
        txPacket   = '0;
        reset_n    = 1'b0;
        test_reset();
        test_single();
        test_timing();
        test_back_to_back();
        test_busy_drop();
        test_reset_abort();
        test_random();
`ifdef SPI_MASTER_BURST_EN
        test_burst();
`else
        test_keep_ignored();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter PACKET_WIDTH, default 8: bits per transfer.
REQ-002 Parameter CLK_DIV, default 5: clk cycles per SCLK half-period; legal values are >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a transfer; sampled only while busy=0.
REQ-006 keepSelect  input  1  hold spi_SSEL low after this packet; sampled with start.
REQ-007 txPacket  input  PACKET_WIDTH  data to send; captured on the accepted start.
REQ-008 busy  output  1  transfer in progress; start is ignored while high.
REQ-009 done  output  1  one-cycle pulse when rxPacket is valid.
REQ-010 rxPacket  output  PACKET_WIDTH  data received; held until the next done.
REQ-011 spi_SCLK  output  1  SPI clock; idles low.
REQ-012 spi_SSEL  output  1  slave select, active low.
REQ-013 spi_MOSI  output  1  master data out, MSB first.
REQ-014 spi_MISO  input  1  slave data in.

Function
REQ-015 Mode: SCLK idles low; both ends sample on the SCLK rising edge; both ends change data on the SCLK falling edge.
REQ-016 All SPI outputs shall be registered, with no combinational path from inputs to outputs.
REQ-017 State machine states: IDLE, LEAD, HIGH, LOW, GUARD.
REQ-018 IDLE: spi_SSEL=1, spi_SCLK=0, busy=0.
REQ-019 IDLE, start=1: capture txPacket into the TX shift register and keepSelect into a flag, then go to LEAD.
REQ-020 In the next cycle: busy=1, spi_SSEL=0, spi_MOSI=txPacket[PACKET_WIDTH-1].
REQ-021 LEAD: lasts CLK_DIV cycles with spi_SCLK=0, then goes to HIGH.
REQ-022 HIGH: spi_SCLK=1 for CLK_DIV cycles.
REQ-023 The RX shift register shall capture spi_MISO on the clk edge that drives spi_SCLK from 0 to 1, shifting in at the LSB.
REQ-024 LOW: spi_SCLK=0 for CLK_DIV cycles.
REQ-025 On entry to LOW, spi_MOSI advances to the next lower bit when bits remain.
REQ-026 A bit counter shall count PACKET_WIDTH HIGH phases.
REQ-027 After the LOW phase of the last bit: rxPacket is loaded, done=1 for exactly one cycle, and the state goes to GUARD.
REQ-028 An accepted start shall produce done exactly CLK_DIV*(2*PACKET_WIDTH+1)+1 cycles later (86 cycles at the defaults).
REQ-029 GUARD (select released): spi_SSEL=1 and spi_SCLK=0 for CLK_DIV cycles, then go to IDLE with busy=0.
REQ-030 A start that arrives while busy=1 shall be dropped, not queued.
REQ-031 spi_MOSI shall hold its last driven value while idle.
REQ-032 rxPacket shall not change between done pulses.
REQ-033 CLK_DIV and PACKET_WIDTH shall be usable at any legal value; counter widths shall derive from $clog2.

Reset
REQ-034 reset_n=0 at a clock edge shall force, from the next cycle: IDLE, busy=0, done=0, rxPacket=0, spi_SSEL=1, spi_SCLK=0, spi_MOSI=0, counters=0.
REQ-035 Reset mid-transfer shall abort immediately, with no done pulse and no partial rxPacket update.
REQ-036 Reset has priority over start.

Configuration
REQ-037 Macro SPI_MASTER_BURST_EN, when defined, enables burst mode.
REQ-038 Burst mode, keepSelect latched as 1: GUARD is replaced by a HOLD state with spi_SSEL=0 and spi_SCLK=0, and busy=0 so a new start is accepted.
REQ-039 Burst mode, start accepted in HOLD: go to LEAD with spi_SSEL kept low throughout.
REQ-040 Burst mode, start=0 in HOLD: stay in HOLD; keepSelect is ignored while in HOLD.
REQ-041 Burst mode, start=1 with keepSelect=0 accepted in HOLD: the resulting transfer ends through GUARD.
REQ-042 Macro undefined: the keepSelect port exists but is ignored, and every transfer ends through GUARD.

Verification
REQ-043 Single transfer: CLK_DIV=5; start with txPacket=8'hab while a bench slave returns 8'hff -> MOSI bits 1,0,1,0,1,0,1,1 stable at each SCLK rise; done at cycle 86; rxPacket=8'hff.
REQ-044 Back-to-back transfers: 8'h15 with slave 8'ha5, then 8'hab with slave 8'h3c -> rxPacket 8'ha5 then 8'h3c; SSEL high for >= 5 cycles between packets.
REQ-045 Busy drop: start pulsed at cycle 20 of a transfer -> exactly one done; the second txPacket is never driven.
REQ-046 Reset abort: reset_n=0 during bit 4 -> next cycle SSEL=1, SCLK=0, busy=0, rxPacket=0, no done.
REQ-047 Burst (SPI_MASTER_BURST_EN defined): 8'hab and 8'h15 with keepSelect=1 then 0 -> SSEL never rises between packets; exactly 16 SCLK rises; final rxPacket matches the slave.
REQ-048 Timing check -> every SCLK high and low phase is exactly CLK_DIV cycles, and LEAD is exactly CLK_DIV cycles (5 at default).
